branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 185 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Tracks predicted branches from decode in a small in-order FIFO and resolves
// the oldest one when execute reports its outcome. Every resolve produces one
// cycle of predictor-training feedback. A wrong prediction squashes all
// in-flight entries, pulses o_flush and holds a fetch redirect until fetch
// accepts it.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   i_push_*                 decode-stage predicted branch (pc, prediction, recovery target)
//   o_push_ready             entry accepted when i_push_valid && o_push_ready
//   i_res_valid/i_res_outcome  execute-stage resolution of the oldest entry
//   o_fb_*                   predictor-training feedback, one cycle per resolve
//   o_redirect_*/i_redirect_ready  fetch redirect handshake
//   o_flush                  one-cycle wrong-path squash pulse
//   o_count                  FIFO occupancy
//   o_branch_count/o_mispredict_count  saturating statistics
//   o_underflow              sticky: resolve seen with empty FIFO
//   o_dbg_state              FSM state (0=IDLE, 1=REDIRECT)
//
// Handshakes: a transfer happens on a rising clk edge where the producer's
// valid and the consumer's ready are both high; the producer holds its
// payload stable while valid is high and ready is low.

module branch_resolve_unit #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push_valid,
  input  logic [ADDR_WIDTH-1:0]    i_push_pc,
  input  logic                     i_push_prediction,
  input  logic [ADDR_WIDTH-1:0]    i_push_recovery_target,
  output logic                     o_push_ready,
  input  logic                     i_res_valid,
  input  logic                     i_res_outcome,
  output logic                     o_fb_valid,
  output logic [ADDR_WIDTH-1:0]    o_fb_pc,
  output logic                     o_fb_prediction,
  output logic                     o_fb_outcome,
  output logic                     o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]    o_redirect_pc,
  input  logic                     i_redirect_ready,
  output logic                     o_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_branch_count,
  output logic [31:0]              o_mispredict_count,
  output logic                     o_underflow,
  output logic                     o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    fb_valid_q, fb_valid_d;
  logic [ADDR_WIDTH-1:0]   fb_pc_q, fb_pc_d;
  logic                    fb_prediction_q, fb_prediction_d;
  logic                    fb_outcome_q, fb_outcome_d;
  logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic                    flush_q, flush_d;
  logic [31:0]             branch_count_q, branch_count_d;
  logic [31:0]             mispredict_count_q, mispredict_count_d;
  logic                    underflow_q, underflow_d;

  // Entry storage is not reset: occupancy and pointers define validity.
  logic [ADDR_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic                    pred_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   tgt_mem_q  [DEPTH];

  logic idle, push_ready, push, resolve, mispredict, head_pred;

  assign idle       = (state_q == IDLE);
  // Readiness uses pre-pop occupancy, so a full FIFO refuses a push even in
  // a cycle where it also pops.
  assign push_ready = idle && (count_q < CW'(DEPTH));
  assign push       = i_push_valid && push_ready;
  assign resolve    = i_res_valid && idle && (count_q != '0);
  assign head_pred  = pred_mem_q[rd_ptr_q];
  assign mispredict = resolve && (head_pred != i_res_outcome);

  always_comb begin
    state_d            = state_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    count_d            = count_q;
    fb_valid_d         = resolve;
    fb_pc_d            = fb_pc_q;
    fb_prediction_d    = fb_prediction_q;
    fb_outcome_d       = fb_outcome_q;
    redirect_pc_d      = redirect_pc_q;
    flush_d            = mispredict;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    underflow_d        = underflow_q | (i_res_valid && idle && (count_q == '0));

    if (resolve) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      count_d         = count_q - CW'(1);
      fb_pc_d         = pc_mem_q[rd_ptr_q];
      fb_prediction_d = head_pred;
      fb_outcome_d    = i_res_outcome;
      if (branch_count_q != 32'hFFFF_FFFF) branch_count_d = branch_count_q + 32'd1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_d + CW'(1);
    end

    // A mispredict discards everything in flight, including a same-cycle push.
    if (mispredict) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      redirect_pc_d = tgt_mem_q[rd_ptr_q];
      state_d       = REDIRECT;
      if (mispredict_count_q != 32'hFFFF_FFFF) mispredict_count_d = mispredict_count_q + 32'd1;
    end

    if (state_q == REDIRECT && i_redirect_ready) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      fb_valid_q         <= 1'b0;
      fb_pc_q            <= '0;
      fb_prediction_q    <= 1'b0;
      fb_outcome_q       <= 1'b0;
      redirect_pc_q      <= '0;
      flush_q            <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      underflow_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      fb_valid_q         <= fb_valid_d;
      fb_pc_q            <= fb_pc_d;
      fb_prediction_q    <= fb_prediction_d;
      fb_outcome_q       <= fb_outcome_d;
      redirect_pc_q      <= redirect_pc_d;
      flush_q            <= flush_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      underflow_q        <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= i_push_pc;
      pred_mem_q[wr_ptr_q] <= i_push_prediction;
      tgt_mem_q[wr_ptr_q]  <= i_push_recovery_target;
    end
  end

  assign o_push_ready       = push_ready;
  assign o_fb_valid         = fb_valid_q;
  assign o_fb_pc            = fb_pc_q;
  assign o_fb_prediction    = fb_prediction_q;
  assign o_fb_outcome       = fb_outcome_q;
  assign o_redirect_valid   = (state_q == REDIRECT);
  assign o_redirect_pc      = redirect_pc_q;
  assign o_flush            = flush_q;
  assign o_count            = count_q;
  assign o_branch_count     = branch_count_q;
  assign o_mispredict_count = mispredict_count_q;
  assign o_underflow        = underflow_q;
  assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit (DEPTH=4, ADDR_WIDTH=32).
// Directed steps in one initial block drive a transaction-level model; the
// expected feedback records are queued when a resolve is driven and popped by
// a monitor when the DUT raises o_fb_valid.

module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_push_valid = 1'b0;
  logic [AW-1:0] i_push_pc = '0;
  logic          i_push_prediction = 1'b0;
  logic [AW-1:0] i_push_recovery_target = '0;
  logic          o_push_ready;
  logic          i_res_valid = 1'b0;
  logic          i_res_outcome = 1'b0;
  logic          o_fb_valid;
  logic [AW-1:0] o_fb_pc;
  logic          o_fb_prediction;
  logic          o_fb_outcome;
  logic          o_redirect_valid;
  logic [AW-1:0] o_redirect_pc;
  logic          i_redirect_ready = 1'b0;
  logic          o_flush;
  logic [$clog2(DEPTH):0] o_count;
  logic [31:0]   o_branch_count;
  logic [31:0]   o_mispredict_count;
  logic          o_underflow;
  logic          o_dbg_state;

  branch_resolve_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_push_valid(i_push_valid), .i_push_pc(i_push_pc),
    .i_push_prediction(i_push_prediction),
    .i_push_recovery_target(i_push_recovery_target),
    .o_push_ready(o_push_ready),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc),
    .o_fb_prediction(o_fb_prediction), .o_fb_outcome(o_fb_outcome),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .i_redirect_ready(i_redirect_ready),
    .o_flush(o_flush), .o_count(o_count),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count),
    .o_underflow(o_underflow), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  logic [33:0] exp_q[$];      // {pc, prediction, outcome} of each expected feedback
  logic [64:0] m_q[$];        // model FIFO: {pc, prediction, recovery_target}
  logic        m_redir = 1'b0;
  logic [31:0] m_rpc = '0;
  logic [31:0] m_br = '0;
  logic [31:0] m_misp = '0;
  logic        m_uf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && o_fb_valid) begin
      check("fb_expected_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fb_pc", 64'(o_fb_pc), 64'(e[33:2]));
        check("fb_prediction", 64'(o_fb_prediction), 64'(e[1]));
        check("fb_outcome", 64'(o_fb_outcome), 64'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_push_valid = 1'b0;
    i_push_pc = '0;
    i_push_prediction = 1'b0;
    i_push_recovery_target = '0;
    i_res_valid = 1'b0;
    i_res_outcome = 1'b0;
    i_redirect_ready = 1'b0;
  endtask

  // One clock cycle of stimulus with model update and post-edge checks.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic pred,
                       input logic [31:0] tgt, input logic rv, input logic oc,
                       input logic rdy);
    logic m_ready, m_res, m_mis;
    logic [64:0] head;
    i_push_valid = pv;
    i_push_pc = pc;
    i_push_prediction = pred;
    i_push_recovery_target = tgt;
    i_res_valid = rv;
    i_res_outcome = oc;
    i_redirect_ready = rdy;
    m_ready = !m_redir && (m_q.size() < DEPTH);
    check("push_ready", 64'(o_push_ready), 64'(m_ready));
    m_res = rv && !m_redir && (m_q.size() > 0);
    m_mis = 1'b0;
    if (rv && !m_redir && m_q.size() == 0) m_uf = 1'b1;
    if (m_res) begin
      head = m_q.pop_front();
      exp_q.push_back({head[64:33], head[32], oc});
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (head[32] != oc) begin
        m_mis = 1'b1;
        if (m_misp != 32'hFFFF_FFFF) m_misp++;
        m_q.delete();
        m_rpc = head[31:0];
      end
    end
    if (pv && m_ready && !m_mis) m_q.push_back({pc, pred, tgt});
    if (m_redir && rdy) m_redir = 1'b0;
    if (m_mis) m_redir = 1'b1;
    tick();
    check("count", 64'(o_count), 64'(m_q.size()));
    check("fb_valid", 64'(o_fb_valid), 64'(m_res));
    check("flush", 64'(o_flush), 64'(m_mis));
    check("redirect_valid", 64'(o_redirect_valid), 64'(m_redir));
    check("dbg_state", 64'(o_dbg_state), 64'(m_redir));
    if (m_redir) check("redirect_pc", 64'(o_redirect_pc), 64'(m_rpc));
    check("branch_count", 64'(o_branch_count), 64'(m_br));
    check("mispredict_count", 64'(o_mispredict_count), 64'(m_misp));
    check("underflow", 64'(o_underflow), 64'(m_uf));
    clear_inputs();
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    cycle(1'b1, pc, pred, tgt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic oc, input logic rdy);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, oc, rdy);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    m_q.delete();
    exp_q.delete();
    m_redir = 1'b0;
    m_rpc = '0;
    m_br = '0;
    m_misp = '0;
    m_uf = 1'b0;
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_fb_valid", 64'(o_fb_valid), 64'd0);
    check("rst_fb_pc", 64'(o_fb_pc), 64'd0);
    check("rst_redirect_valid", 64'(o_redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(o_redirect_pc), 64'd0);
    check("rst_flush", 64'(o_flush), 64'd0);
    check("rst_underflow", 64'(o_underflow), 64'd0);
    check("rst_branch_count", 64'(o_branch_count), 64'd0);
    check("rst_mispredict_count", 64'(o_mispredict_count), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    rst_n = 1'b1;
    check("rst_push_ready", 64'(o_push_ready), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    tick();
    do_reset();

    // Underflow: resolve with empty FIFO only sets the sticky flag.
    resolve(1'b0, 1'b0);
    check("uf_flag", 64'(o_underflow), 64'd1);
    idle(1'b0);

    // Correct-path resolution.
    push(32'h100, 1'b0, 32'h104);
    resolve(1'b0, 1'b0);
    check("cp_fb_pc", 64'(o_fb_pc), 64'h100);
    check("cp_branch_count", 64'(o_branch_count), 64'd1);
    idle(1'b0);

    // Mispredict and redirect held for three refused cycles.
    push(32'h200, 1'b1, 32'h208);
    push(32'h300, 1'b0, 32'h308);
    resolve(1'b0, 1'b0);
    check("mp_redirect_pc", 64'(o_redirect_pc), 64'h208);
    cycle(1'b1, 32'h400, 1'b0, 32'h404, 1'b1, 1'b0, 1'b0); // ignored in REDIRECT
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);                                           // handshake
    check("mp_count", 64'(o_count), 64'd0);
    idle(1'b0);

    // Full FIFO: fifth push refused; resolve+push keeps the push out.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 4, 1'b0, 32'h2000);
    push(32'h1100, 1'b0, 32'h2000);
    check("full_count", 64'(o_count), 64'd4);
    cycle(1'b1, 32'h1200, 1'b0, 32'h2000, 1'b1, 1'b0, 1'b0);
    check("full_pop_count", 64'(o_count), 64'd3);
    for (int i = 0; i < 3; i++) resolve(1'b0, 1'b0);
    idle(1'b0);

    // Pointer wrap: ten correct push/resolve pairs.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(32'h5000 + 32'(i) * 16, 1'(i % 2), 32'h9000);
      resolve(1'(i % 2), 1'b0);
    end
    check("wrap_branch_count", 64'(o_branch_count), 64'd10);
    idle(1'b0);

    // Reset while in REDIRECT with entries in flight.
    push(32'h600, 1'b1, 32'h608);
    push(32'h700, 1'b1, 32'h708);
    resolve(1'b0, 1'b0);
    check("rr_in_redirect", 64'(o_redirect_valid), 64'd1);
    do_reset();
    idle(1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)) << 2,
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFFF)) << 2,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
